// File: rtl/text_memory_arbiter_pkg.sv
// Shared configuration and type definitions for the text-memory arbiter.
package rv_config;
    // Byte-address width of the text (instruction) memory.
    localparam int TEXT_BITS = 14;
endpackage

package rv_constants;
    // Arbiter ownership states.
    typedef enum logic [1:0] {
        ARB_SHARED  = 2'd0,
        ARB_LOCKING = 2'd1,
        ARB_LOCKED  = 2'd2
    } arb_state_e;

    // Requester identity, used for round-robin bookkeeping.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DEBUG = 1'b1
    } requester_e;
endpackage

// File: rtl/text_memory_rr_pick.sv
// Two-way round-robin pick between instruction fetch and debug port.
// Each grant depends only on the other side's request and the last winner,
// so it can be used directly as that requester's ready.
module text_memory_rr_pick
    import rv_constants::*;
(
    input  logic       fetch_req,
    input  logic       dbg_req,
    input  requester_e last_grant,
    output logic       fetch_gnt,
    output logic       dbg_gnt
);

    // A side may go if the other is idle, or if the other won last time.
    always_comb begin
        fetch_gnt = !dbg_req   || (last_grant == REQ_DEBUG);
        dbg_gnt   = !fetch_req || (last_grant == REQ_FETCH);
    end

endmodule

// File: rtl/text_memory_arbiter.sv
// Arbitrates a single-port synchronous text memory between the core's
// instruction fetch and a debug/loader port, with an exclusive lock mode
// for the debug side. Memory requests are issued combinationally in the
// accept cycle; responses return exactly one cycle later.
module text_memory_arbiter
    import rv_constants::*;
#(
    parameter int ADDR_BITS  = rv_config::TEXT_BITS - 2,
    parameter int STALL_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [ADDR_BITS-1:0]  fetch_addr,
    output logic                  fetch_rsp_valid,
    output logic [31:0]           fetch_rsp_data,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_write,
    input  logic [ADDR_BITS-1:0]  dbg_addr,
    input  logic [31:0]           dbg_wdata,
    input  logic [3:0]            dbg_wmask,
    input  logic                  dbg_lock,
    output logic                  dbg_rsp_valid,
    output logic [31:0]           dbg_rsp_data,
    output logic [ADDR_BITS-1:0]  mem_address,
    output logic                  mem_write,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byteena,
    input  logic [31:0]           mem_q,
    output logic                  locked,
    output logic [STALL_BITS-1:0] fetch_stall_count
);

    arb_state_e            state_q, state_d;
    requester_e            last_grant_q, last_grant_d;
    logic [STALL_BITS-1:0] stall_q, stall_d;
    logic                  fetch_rsp_valid_q, fetch_rsp_valid_d;
    logic                  dbg_rsp_valid_q, dbg_rsp_valid_d;
    logic                  dbg_rsp_write_q, dbg_rsp_write_d;
    logic [ADDR_BITS-1:0]  mem_address_q, mem_address_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_byteena_q, mem_byteena_d;
    logic                  rr_fetch_gnt, rr_dbg_gnt;
    logic                  fetch_acc, dbg_acc;

    text_memory_rr_pick u_rr_pick (
        .fetch_req  (fetch_req_valid),
        .dbg_req    (dbg_req_valid),
        .last_grant (last_grant_q),
        .fetch_gnt  (rr_fetch_gnt),
        .dbg_gnt    (rr_dbg_gnt)
    );

    // State and bookkeeping registers; reset also discards in-flight responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ARB_SHARED;
            last_grant_q      <= REQ_DEBUG;
            stall_q           <= '0;
            fetch_rsp_valid_q <= 1'b0;
            dbg_rsp_valid_q   <= 1'b0;
            dbg_rsp_write_q   <= 1'b0;
            mem_address_q     <= '0;
            mem_wdata_q       <= '0;
            mem_byteena_q     <= '0;
        end else begin
            state_q           <= state_d;
            last_grant_q      <= last_grant_d;
            stall_q           <= stall_d;
            fetch_rsp_valid_q <= fetch_rsp_valid_d;
            dbg_rsp_valid_q   <= dbg_rsp_valid_d;
            dbg_rsp_write_q   <= dbg_rsp_write_d;
            mem_address_q     <= mem_address_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_byteena_q     <= mem_byteena_d;
        end
    end

    // Lock sequencing: LOCKING is a fixed one-cycle drain before LOCKED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_SHARED:  if (dbg_lock) state_d = ARB_LOCKING;
            ARB_LOCKING: state_d = ARB_LOCKED;
            ARB_LOCKED:  if (!dbg_lock) state_d = ARB_SHARED;
            default:     state_d = ARB_SHARED;
        endcase
    end

    // Ready per state; nothing is accepted while reset is asserted.
    always_comb begin
        fetch_req_ready = 1'b0;
        dbg_req_ready   = 1'b0;
        if (reset_n) begin
            case (state_q)
                ARB_SHARED: begin
                    fetch_req_ready = rr_fetch_gnt;
                    dbg_req_ready   = rr_dbg_gnt;
                end
                ARB_LOCKED: dbg_req_ready = 1'b1;
                default: ;
            endcase
        end
        locked = (state_q == ARB_LOCKED);
    end

    // Memory request steering, response tracking and stall counting.
    always_comb begin
        fetch_acc         = fetch_req_valid && fetch_req_ready;
        dbg_acc           = dbg_req_valid && dbg_req_ready;
        last_grant_d      = last_grant_q;
        mem_address_d     = mem_address_q;
        mem_wdata_d       = mem_wdata_q;
        mem_byteena_d     = mem_byteena_q;
        mem_write         = 1'b0;
        fetch_rsp_valid_d = fetch_acc;
        dbg_rsp_valid_d   = dbg_acc;
        dbg_rsp_write_d   = dbg_acc && dbg_req_write;
        stall_d           = stall_q;

        if (dbg_acc) begin
            last_grant_d  = REQ_DEBUG;
            mem_address_d = dbg_addr;
            mem_wdata_d   = dbg_wdata;
            if (dbg_req_write) begin
                mem_write     = 1'b1;
                mem_byteena_d = dbg_wmask;
            end else begin
                mem_byteena_d = 4'hF;
            end
        end else if (fetch_acc) begin
            last_grant_d  = REQ_FETCH;
            mem_address_d = fetch_addr;
            mem_byteena_d = 4'hF;
        end

        // Saturating count of fetch cycles that were held off.
        if (fetch_req_valid && !fetch_req_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    assign mem_address       = mem_address_d;
    assign mem_wdata         = mem_wdata_d;
    assign mem_byteena       = mem_byteena_d;
    assign fetch_rsp_valid   = fetch_rsp_valid_q;
    assign fetch_rsp_data    = fetch_rsp_valid_q ? mem_q : 32'h0;
    assign dbg_rsp_valid     = dbg_rsp_valid_q;
    assign dbg_rsp_data      = (dbg_rsp_valid_q && !dbg_rsp_write_q) ? mem_q : 32'h0;
    assign fetch_stall_count = stall_q;

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Directed bench for text_memory_arbiter with a behavioural synchronous memory.
module tb_text_memory_arbiter;
    import rv_constants::*;

    localparam int AB = rv_config::TEXT_BITS - 2;
    localparam int SB = 4;

    logic          clock;
    logic          reset_n;
    logic          fetch_req_valid;
    logic          fetch_req_ready;
    logic [AB-1:0] fetch_addr;
    logic          fetch_rsp_valid;
    logic [31:0]   fetch_rsp_data;
    logic          dbg_req_valid;
    logic          dbg_req_ready;
    logic          dbg_req_write;
    logic [AB-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [3:0]    dbg_wmask;
    logic          dbg_lock;
    logic          dbg_rsp_valid;
    logic [31:0]   dbg_rsp_data;
    logic [AB-1:0] mem_address;
    logic          mem_write;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byteena;
    logic [31:0]   mem_q;
    logic          locked;
    logic [SB-1:0] fetch_stall_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] tmem [0:(1<<AB)-1];

    text_memory_arbiter #(.ADDR_BITS(AB), .STALL_BITS(SB)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .fetch_req_valid   (fetch_req_valid),
        .fetch_req_ready   (fetch_req_ready),
        .fetch_addr        (fetch_addr),
        .fetch_rsp_valid   (fetch_rsp_valid),
        .fetch_rsp_data    (fetch_rsp_data),
        .dbg_req_valid     (dbg_req_valid),
        .dbg_req_ready     (dbg_req_ready),
        .dbg_req_write     (dbg_req_write),
        .dbg_addr          (dbg_addr),
        .dbg_wdata         (dbg_wdata),
        .dbg_wmask         (dbg_wmask),
        .dbg_lock          (dbg_lock),
        .dbg_rsp_valid     (dbg_rsp_valid),
        .dbg_rsp_data      (dbg_rsp_data),
        .mem_address       (mem_address),
        .mem_write         (mem_write),
        .mem_wdata         (mem_wdata),
        .mem_byteena       (mem_byteena),
        .mem_q             (mem_q),
        .locked            (locked),
        .fetch_stall_count (fetch_stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port memory: read returns old data, q one cycle later.
    always @(posedge clock) begin
        mem_q <= tmem[mem_address];
        if (mem_write) begin
            if (mem_byteena[0]) tmem[mem_address][7:0]   = mem_wdata[7:0];
            if (mem_byteena[1]) tmem[mem_address][15:8]  = mem_wdata[15:8];
            if (mem_byteena[2]) tmem[mem_address][23:16] = mem_wdata[23:16];
            if (mem_byteena[3]) tmem[mem_address][31:24] = mem_wdata[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        tmem[12'h010] = 32'h0000_0013;
        tmem[12'h020] = 32'h1111_1111;
        tmem[12'h030] = 32'h2222_2222;
        tmem[12'h040] = 32'hFFFF_FFFF;

        reset_n = 1'b0; fetch_req_valid = 1'b0; fetch_addr = '0;
        dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_addr = '0;
        dbg_wdata = '0; dbg_wmask = '0; dbg_lock = 1'b0;

        // Reset state
        #1;
        chk("rst_fetch_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
        chk("rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_byteena", 32'(mem_byteena), 32'd0);
        chk("rst_stall", 32'(fetch_stall_count), 32'd0);
        @(negedge clock); reset_n = 1'b1;

        // Fetch only, first edge after release
        @(negedge clock); fetch_req_valid = 1'b1; fetch_addr = 12'h010; #1;
        chk("f_ready", 32'(fetch_req_ready), 32'd1);
        chk("f_mem_addr", 32'(mem_address), 32'h010);
        chk("f_mem_write", 32'(mem_write), 32'd0);
        chk("f_byteena", 32'(mem_byteena), 32'hF);

        // Debug write 0x040, while fetch response returns
        @(negedge clock); fetch_req_valid = 1'b0;
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_addr = 12'h040;
        dbg_wdata = 32'hDEAD_BEEF; dbg_wmask = 4'b0011; #1;
        chk("f_rsp_valid", 32'(fetch_rsp_valid), 32'd1);
        chk("f_rsp_data", fetch_rsp_data, 32'h0000_0013);
        chk("f_dbg_rsp_quiet", 32'(dbg_rsp_valid), 32'd0);
        chk("w_ready", 32'(dbg_req_ready), 32'd1);
        chk("w_mem_write", 32'(mem_write), 32'd1);
        chk("w_byteena", 32'(mem_byteena), 32'h3);
        chk("w_mem_addr", 32'(mem_address), 32'h040);
        chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);

        // Debug read back 0x040
        @(negedge clock); dbg_req_write = 1'b0; #1;
        chk("w_ack_valid", 32'(dbg_rsp_valid), 32'd1);
        chk("w_ack_data", dbg_rsp_data, 32'd0);
        chk("w_f_rsp_quiet", 32'(fetch_rsp_valid), 32'd0);
        chk("r_mem_write", 32'(mem_write), 32'd0);
        chk("r_byteena", 32'(mem_byteena), 32'hF);

        @(negedge clock); dbg_req_valid = 1'b0; #1;
        chk("r_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
        chk("r_rsp_data", dbg_rsp_data, 32'hFFFF_BEEF);
        chk("idle_mem_write", 32'(mem_write), 32'd0);
        chk("idle_addr_held", 32'(mem_address), 32'h040);
        chk("idle_byteena_held", 32'(mem_byteena), 32'hF);

        // Both valid: grants F, D, F, D
        @(negedge clock); fetch_req_valid = 1'b1; fetch_addr = 12'h020;
        dbg_req_valid = 1'b1; dbg_addr = 12'h030; #1;
        chk("rr1_f_ready", 32'(fetch_req_ready), 32'd1);
        chk("rr1_d_ready", 32'(dbg_req_ready), 32'd0);
        chk("rr1_addr", 32'(mem_address), 32'h020);
        chk("rr1_d_rsp", 32'(dbg_rsp_valid), 32'd0);
        @(negedge clock); #1;
        chk("rr2_f_ready", 32'(fetch_req_ready), 32'd0);
        chk("rr2_d_ready", 32'(dbg_req_ready), 32'd1);
        chk("rr2_addr", 32'(mem_address), 32'h030);
        chk("rr2_f_rsp", 32'(fetch_rsp_valid), 32'd1);
        chk("rr2_f_data", fetch_rsp_data, 32'h1111_1111);
        chk("rr2_d_rsp", 32'(dbg_rsp_valid), 32'd0);
        @(negedge clock); #1;
        chk("rr3_f_ready", 32'(fetch_req_ready), 32'd1);
        chk("rr3_d_rsp", 32'(dbg_rsp_valid), 32'd1);
        chk("rr3_d_data", dbg_rsp_data, 32'h2222_2222);
        chk("rr3_f_rsp", 32'(fetch_rsp_valid), 32'd0);
        @(negedge clock); #1;
        chk("rr4_d_ready", 32'(dbg_req_ready), 32'd1);
        chk("rr4_f_ready", 32'(fetch_req_ready), 32'd0);
        chk("rr4_f_rsp", 32'(fetch_rsp_valid), 32'd1);
        chk("rr4_f_data", fetch_rsp_data, 32'h1111_1111);
        @(negedge clock); fetch_req_valid = 1'b0; dbg_req_valid = 1'b0; #1;
        chk("rr5_d_rsp", 32'(dbg_rsp_valid), 32'd1);
        chk("rr5_d_data", dbg_rsp_data, 32'h2222_2222);
        chk("rr5_stall", 32'(fetch_stall_count), 32'd2);

        // Lock with continuous fetch
        @(negedge clock); fetch_req_valid = 1'b1; fetch_addr = 12'h010; dbg_lock = 1'b1; #1;
        chk("lk1_f_ready", 32'(fetch_req_ready), 32'd1);
        chk("lk1_locked", 32'(locked), 32'd0);
        @(negedge clock); #1;
        chk("lk2_f_ready", 32'(fetch_req_ready), 32'd0);
        chk("lk2_d_ready", 32'(dbg_req_ready), 32'd0);
        chk("lk2_locked", 32'(locked), 32'd0);
        chk("lk2_f_rsp", fetch_rsp_data, 32'h0000_0013);
        chk("lk2_stall", 32'(fetch_stall_count), 32'd2);
        @(negedge clock); #1;
        chk("lk3_locked", 32'(locked), 32'd1);
        chk("lk3_f_ready", 32'(fetch_req_ready), 32'd0);
        chk("lk3_d_ready", 32'(dbg_req_ready), 32'd1);
        chk("lk3_stall", 32'(fetch_stall_count), 32'd3);
        @(negedge clock); dbg_lock = 1'b0; #1;
        chk("lk4_locked", 32'(locked), 32'd1);
        chk("lk4_stall", 32'(fetch_stall_count), 32'd4);
        @(negedge clock); #1;
        chk("lk5_locked", 32'(locked), 32'd0);
        chk("lk5_f_ready", 32'(fetch_req_ready), 32'd1);
        chk("lk5_stall", 32'(fetch_stall_count), 32'd5);
        @(negedge clock); fetch_req_valid = 1'b0; #1;
        chk("lk6_stall", 32'(fetch_stall_count), 32'd5);
        chk("lk6_f_rsp", 32'(fetch_rsp_valid), 32'd1);

        // Saturation of the stall counter
        @(negedge clock); fetch_req_valid = 1'b1; dbg_lock = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clock);
        #1;
        chk("sat_stall", 32'(fetch_stall_count), 32'hF);
        chk("sat_locked", 32'(locked), 32'd1);
        dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_addr = 12'h030; #1;
        chk("lkrd_d_ready", 32'(dbg_req_ready), 32'd1);
        chk("lkrd_f_ready", 32'(fetch_req_ready), 32'd0);
        @(negedge clock); dbg_req_valid = 1'b0; dbg_lock = 1'b0; #1;
        chk("lkrd_rsp_data", dbg_rsp_data, 32'h2222_2222);
        chk("sat_hold", 32'(fetch_stall_count), 32'hF);
        @(negedge clock); fetch_req_valid = 1'b0; #1;
        chk("unlk_locked", 32'(locked), 32'd0);
        chk("sat_hold2", 32'(fetch_stall_count), 32'hF);

        // Reset right after a fetch accept drops its response
        @(negedge clock); fetch_req_valid = 1'b1; fetch_addr = 12'h010; #1;
        chk("rs_f_ready", 32'(fetch_req_ready), 32'd1);
        @(negedge clock); fetch_req_valid = 1'b0; reset_n = 1'b0; #1;
        chk("rs_f_rsp", 32'(fetch_rsp_valid), 32'd0);
        chk("rs_stall", 32'(fetch_stall_count), 32'd0);
        chk("rs_mem_address", 32'(mem_address), 32'd0);
        chk("rs_mem_byteena", 32'(mem_byteena), 32'd0);
        chk("rs_mem_write", 32'(mem_write), 32'd0);
        chk("rs_locked", 32'(locked), 32'd0);
        @(negedge clock); reset_n = 1'b1; #1;
        chk("rs_f_rsp_after", 32'(fetch_rsp_valid), 32'd0);
        fetch_req_valid = 1'b1; dbg_req_valid = 1'b1; #1;
        chk("rs_tie_f_ready", 32'(fetch_req_ready), 32'd1);
        chk("rs_tie_d_ready", 32'(dbg_req_ready), 32'd0);
        @(negedge clock); fetch_req_valid = 1'b0; dbg_req_valid = 1'b0; #1;
        chk("rs_post_f_rsp", 32'(fetch_rsp_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
